// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO burst reader.
//   state_t        : burst FSM state encoding (IDLE, RUN, FLUSH)
//   DEF_DATA_W     : default width of FIFO read data and stream data
//   DEF_BURST_LEN  : default number of words per burst
package fifo_pkg;

    localparam int unsigned DEF_DATA_W    = 64;
    localparam int unsigned DEF_BURST_LEN = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order holding buffer between the FIFO read port and the stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data into the next free entry (caller never overfills)
//   push_data  : entry payload
//   pop        : retire the head entry (ignored when empty)
//   head       : oldest entry, stable until popped
//   count      : number of occupied entries (0..2)
module stream_skid_buf #(
    parameter int unsigned W = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_pop;

    assign do_pop = pop && (count != 2'd0);
    assign head   = mem[rd_ptr];

    // Entry storage, ring pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Reads fixed-length bursts from a synchronous FIFO and presents them as a
// valid/ready stream with a last-of-burst marker.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : permits starting a new burst (a running burst always completes)
//   fifo_empty  : FIFO empty flag
//   fifo_dout   : FIFO read data, valid one cycle after an accepted read
//   fifo_rd_en  : FIFO read strobe
//   m_data      : stream data
//   m_valid     : stream data valid
//   m_ready     : downstream accepts
//   m_last      : final word of the burst
//   busy        : burst in progress or data still held
//   word_count  : total stream transfers, wraps mod 2^32
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic [31:0]       word_count
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned BUF_W = DATA_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] rd_cnt;
    logic             in_flight;
    logic             in_flight_last;
    logic [1:0]       buf_count;
    logic [BUF_W-1:0] buf_head;
    logic             pop;
    logic             last_rd;
    logic             room;
    logic [2:0]       level;

    assign m_valid = (buf_count != 2'd0);
    assign pop     = m_valid & m_ready;
    assign last_rd = (rd_cnt == LAST_IDX);

    // The word leaving on the stream this cycle frees its slot, so the
    // steady state (one held, one in flight, one popping) keeps reading.
    assign level = 3'(buf_count) + 3'(in_flight) - 3'(pop);
    assign room  = (level < 3'd2);

    assign m_data = buf_head[DATA_W-1:0];
    assign m_last = m_valid & buf_head[DATA_W];
    assign busy   = (state != IDLE) | m_valid;

    // Next state and read strobe; the strobe is qualified with the live
    // empty flag so a read is never presented to an empty FIFO.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!fifo_empty && room) begin
                    fifo_rd_en = 1'b1;
                    if (last_rd) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!in_flight && (buf_count == 2'd0)) begin
                    if (enable && !fifo_empty) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read tracking, burst counter and transfer counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            rd_cnt         <= '0;
            word_count     <= 32'd0;
        end else begin
            in_flight      <= fifo_rd_en;
            in_flight_last <= fifo_rd_en & last_rd;
            if ((state != RUN) && (state_nxt == RUN)) begin
                rd_cnt <= '0;
            end else if (fifo_rd_en) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
            if (pop) begin
                word_count <= word_count + 32'd1;
            end
        end
    end

    // Captured words carry their last-of-burst tag through the buffer
    stream_skid_buf #(
        .W (BUF_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_flight),
        .push_data ({in_flight_last, fifo_dout}),
        .pop       (pop),
        .head      (buf_head),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: cycle table for a full-rate burst plus
// directed sequences for back-pressure, FIFO underrun, enable drop, reset
// mid-burst and word_count wrap. A per-cycle monitor checks stream order,
// m_last placement, hold stability, read gating and word_count.
module tb_fifo_reader;

    localparam int unsigned DATA_W = 64;
    localparam int          BL     = 16;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout = '0;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic [31:0]       word_count;

    fifo_reader #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: write side owned by the stimulus, read side by this process
    logic [63:0] fmem [256];
    logic [7:0]  wr_idx = 8'd0;
    logic [7:0]  rd_idx = 8'd0;

    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= fmem[rd_idx];
            rd_idx    <= rd_idx + 8'd1;
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q [$];
    int          held;
    int          infl;
    int          bidx;
    logic [31:0] wmodel;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        rd_en;
        logic        valid;
        logic [63:0] data;
        logic        last;
        logic        busy;
        logic [31:0] wc;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    task automatic push(input logic [63:0] v);
        fmem[wr_idx] = v;
        wr_idx = wr_idx + 8'd1;
    endtask

    // Per-cycle stream monitor, called at the falling edge
    task automatic mon();
        logic xfer;
        logic acc;
        if (!rst_n) begin
            exp_q.delete();
            held       = 0;
            infl       = 0;
            bidx       = 0;
            wmodel     = 32'd0;
            prev_stall = 1'b0;
            return;
        end
        xfer = m_valid & m_ready;
        acc  = fifo_rd_en & ~fifo_empty;
        chk("mon_valid", 64'(m_valid), 64'(held != 0));
        chk("mon_word_count", 64'(word_count), 64'(wmodel));
        if (fifo_rd_en) begin
            chk("mon_rd_gate", 64'(!fifo_empty && ((held + infl - int'(xfer)) < 2)), 64'd1);
        end
        if (prev_stall) begin
            chk("mon_hold_data", m_data, prev_data);
            chk("mon_hold_last", 64'(m_last), 64'(prev_last));
        end
        if (xfer) begin
            chk("mon_word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                chk("mon_data", m_data, exp_q.pop_front());
            end
            chk("mon_last", 64'(m_last), 64'(bidx == BL - 1));
            bidx   = (bidx + 1) % BL;
            wmodel = wmodel + 32'd1;
        end
        if (acc) begin
            exp_q.push_back(fmem[rd_idx]);
        end
        held       = held + infl - int'(xfer);
        infl       = int'(acc);
        prev_stall = m_valid & ~m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (!busy) done = 1'b1;
        end
        chk(name, 64'(done), 64'd1);
    endtask

    task automatic wait_count(input string name, input logic [31:0] target, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (word_count == target) done = 1'b1;
        end
        chk(name, 64'(done), 64'd1);
    endtask

    initial begin
        // Full-rate burst of words 0..15, cycle 0 = first cycle with enable
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 32'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 32'd0};
        for (int r = 3; r <= 18; r++) begin
            tbl[r] = '{1'b1, 1'b1, 1'(r <= 16), 1'b1, 64'(r - 3), 1'(r == 18), 1'b1, 32'(r - 3)};
        end
        tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 32'd16};
        tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 32'd16};

        rst_n   = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        rst_n = 1'b1;

        // Full-rate burst from the cycle table
        for (int i = 0; i < 16; i++) push(64'(i));
        for (int r = 0; r < 21; r++) begin
            enable  = tbl[r].en;
            m_ready = tbl[r].rdy;
            @(negedge clk);
            mon();
            chk($sformatf("vec%0d_rd_en", r), 64'(fifo_rd_en), 64'(tbl[r].rd_en));
            chk($sformatf("vec%0d_valid", r), 64'(m_valid), 64'(tbl[r].valid));
            if (tbl[r].valid) chk($sformatf("vec%0d_data", r), m_data, tbl[r].data);
            chk($sformatf("vec%0d_last", r), 64'(m_last), 64'(tbl[r].last));
            chk($sformatf("vec%0d_busy", r), 64'(busy), 64'(tbl[r].busy));
            chk($sformatf("vec%0d_wc", r), 64'(word_count), 64'(tbl[r].wc));
            @(posedge clk);
            #1;
        end
        enable = 1'b0;

        // Back-pressure: m_ready toggles every cycle
        for (int i = 0; i < 16; i++) push(64'h100 + 64'(i));
        enable  = 1'b1;
        m_ready = 1'b1;
        begin
            logic done;
            done = 1'b0;
            for (int i = 0; i < 100 && !done; i++) begin
                m_ready = ~m_ready;
                tick();
                if (!busy && word_count == 32'd32) done = 1'b1;
            end
            chk("bp_complete", 64'(done), 64'd1);
        end
        chk("bp_word_count", 64'(word_count), 64'd32);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        enable  = 1'b0;
        m_ready = 1'b1;

        // FIFO underrun mid-burst, then refill
        for (int i = 0; i < 5; i++) push(64'h200 + 64'(i));
        enable = 1'b1;
        repeat (20) tick();
        chk("under_busy", 64'(busy), 64'd1);
        chk("under_valid", 64'(m_valid), 64'd0);
        chk("under_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("under_wc", 64'(word_count), 64'd37);
        for (int i = 5; i < 16; i++) push(64'h200 + 64'(i));
        wait_idle("under_idle", 60);
        chk("under_wc_done", 64'(word_count), 64'd48);
        enable = 1'b0;

        // Enable dropped after three transfers
        for (int i = 0; i < 16; i++) push(64'h500 + 64'(i));
        enable = 1'b1;
        wait_count("drop_three", 32'd51, 20);
        enable = 1'b0;
        wait_idle("drop_idle", 40);
        chk("drop_wc", 64'(word_count), 64'd64);
        chk("drop_drained", 64'(exp_q.size()), 64'd0);
        push(64'h600);
        push(64'h601);
        repeat (5) tick();
        chk("drop_stays_idle", 64'(busy), 64'd0);
        chk("drop_no_read", 64'(fifo_rd_en), 64'd0);

        // Reset with one word held and one read in flight
        for (int i = 2; i < 16; i++) push(64'h600 + 64'(i));
        enable  = 1'b1;
        m_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("rstmid_holding", 64'(m_valid), 64'd1);
        @(negedge clk);
        mon();
        #1;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk("rstmid_valid", 64'(m_valid), 64'd0);
        chk("rstmid_wc", 64'(word_count), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_data", m_data, 64'd0);
        @(posedge clk);
        #1;
        tick();
        tick();
        rst_n = 1'b1;
        push(64'h610);
        push(64'h611);
        repeat (4) tick();
        chk("rstmid_no_stale", 64'(m_valid), 64'd0);
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_idle("rstmid_idle", 60);
        chk("rstmid_wc_done", 64'(word_count), 64'd16);
        chk("rstmid_drained", 64'(exp_q.size()), 64'd0);
        chk("rstmid_fifo_used", 64'(rd_idx == wr_idx), 64'd1);
        enable = 1'b0;

        // word_count wrap
        force dut.word_count = 32'hFFFF_FFFF;
        wmodel = 32'hFFFF_FFFF;
        tick();
        release dut.word_count;
        tick();
        chk("wrap_preset", 64'(word_count), 64'hFFFF_FFFF);
        for (int i = 0; i < 16; i++) push(64'h700 + 64'(i));
        enable = 1'b1;
        wait_idle("wrap_idle", 40);
        chk("wrap_wc", 64'(word_count), 64'd15);
        enable = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
